rom_access_arbiter: RTL and testbench

Sequences all reads of the program/coefficient ROM (ADDR_W-bit address, DATA_W-bit combinational data) and shares it between two requesters: the processor instruction-fetch port (IF) and the image-filter coefficient loader (CF). Each access is a req/gnt handshake followed by a one-cycle rvalid data return. The block drives the ROM address from a register and captures ROM data one cycle later. By default, arbitration between IF and CF is round-robin.

---
 rtl/rom_access_arbiter.sv | 119 +++++++++++
 tb/tb_rom_access_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one combinational ROM between the instruction
// fetch port (IF) and the coefficient loader (CF) with req/gnt + rvalid.
// Ports: clk, rst_n (async, active low); if_req/if_addr -> if_gnt/if_rvalid;
//   cf_req/cf_addr -> cf_gnt/cf_rvalid; rdata (shared read data); busy;
//   ROM_address (registered) / ROM_data (combinational ROM output).
// Build option: ROM_ARB_FIXED_PRIO_EN selects fixed IF-first priority
//   instead of the default round-robin arbitration.
module rom_access_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              cf_req,
    input  logic [ADDR_W-1:0] cf_addr,
    output logic              cf_gnt,
    output logic              cf_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ROM_address,
    input  logic [DATA_W-1:0] ROM_data
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t state_q, state_d;

    // owner/last encode the requester: 0 = IF, 1 = CF
    logic owner_q, owner_d;
    logic last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic if_gnt_q, if_gnt_d;
    logic cf_gnt_q, cf_gnt_d;
    logic if_rv_q, if_rv_d;
    logic cf_rv_q, cf_rv_d;
    logic win_if, win_cf;

    always_comb begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        win_if = if_req;
`else
        // on a tie, IF wins only if CF was served last
        win_if = if_req & (~cf_req | last_q);
`endif
        win_cf = cf_req & ~win_if;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        if_gnt_d = 1'b0;
        cf_gnt_d = 1'b0;
        if_rv_d  = 1'b0;
        cf_rv_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_if | win_cf) begin
                    state_d  = READ;
                    owner_d  = win_cf;
                    last_d   = win_cf;
                    addr_d   = win_cf ? cf_addr : if_addr;
                    if_gnt_d = win_if;
                    cf_gnt_d = win_cf;
                end
            end
            READ: begin
                rdata_d = ROM_data;
                if_rv_d = ~owner_q;
                cf_rv_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            rdata_q  <= '0;
            if_gnt_q <= 1'b0;
            cf_gnt_q <= 1'b0;
            if_rv_q  <= 1'b0;
            cf_rv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            if_gnt_q <= if_gnt_d;
            cf_gnt_q <= cf_gnt_d;
            if_rv_q  <= if_rv_d;
            cf_rv_q  <= cf_rv_d;
        end
    end

    assign if_gnt      = if_gnt_q;
    assign cf_gnt      = cf_gnt_q;
    assign if_rvalid   = if_rv_q;
    assign cf_rvalid   = cf_rv_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q == READ);
    assign ROM_address = addr_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: scoreboard bench for rom_access_arbiter.
// Drivers push expected ROM words per requester; a monitor pops on rvalid.
module tb_rom_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       if_req, cf_req;
    logic [2:0] if_addr, cf_addr;
    logic       if_gnt, cf_gnt, if_rvalid, cf_rvalid, busy;
    logic [7:0] rdata, ROM_data;
    logic [2:0] ROM_address;

    logic [7:0] rom [8];
    logic [7:0] if_q[$];
    logic [7:0] cf_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    assign ROM_data = rom[ROM_address];

    rom_access_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .cf_req(cf_req), .cf_addr(cf_addr),
        .cf_gnt(cf_gnt), .cf_rvalid(cf_rvalid),
        .rdata(rdata), .busy(busy),
        .ROM_address(ROM_address), .ROM_data(ROM_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // monitor: protocol invariants and scoreboard pops
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("one_pulse",
                32'($countones({if_gnt, cf_gnt, if_rvalid, cf_rvalid}) <= 1),
                32'd1);
            chk("busy_vs_gnt", {31'd0, busy}, {31'd0, if_gnt | cf_gnt});
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_rvalid_unexpected got=1 exp=0");
                end else chk("if_rdata", {24'd0, rdata},
                             {24'd0, if_q.pop_front()});
            end
            if (cf_rvalid) begin
                if (cf_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cf_rvalid_unexpected got=1 exp=0");
                end else chk("cf_rdata", {24'd0, rdata},
                             {24'd0, cf_q.pop_front()});
            end
        end
    end

    // one request: raise req, expect ROM word, wait for gnt, drop req
    task automatic do_req(input bit cf, input logic [2:0] a, output int gc);
        bit got = 1'b0;
        if (cf) begin
            cf_req = 1'b1; cf_addr = a; cf_q.push_back(rom[a]);
        end else begin
            if_req = 1'b1; if_addr = a; if_q.push_back(rom[a]);
        end
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            got = cf ? cf_gnt : if_gnt;
        end
        gc = cyc;
        if (cf) cf_req = 1'b0; else if_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt_timeout side=%0d got=0 exp=1", cf);
            if (cf) void'(cf_q.pop_back()); else void'(if_q.pop_back());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1, g2, grants, lastc, who, expw, t;
        bit got;
        for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
        rom[1] = 8'hA5;
        if_req = 0; cf_req = 0; if_addr = 0; cf_addr = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_req = 1'($urandom); cf_req = 1'($urandom);
            if_addr = 3'($urandom); cf_addr = 3'($urandom);
            #1 chk("reset_outs",
                   {13'd0, if_gnt, cf_gnt, if_rvalid, cf_rvalid, busy,
                    rdata, ROM_address}, 32'd0);
        end
        @(negedge clk);
        if_req = 0; cf_req = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {28'd0, if_gnt, cf_gnt, if_rvalid, cf_rvalid},
                32'd0);
        end

        // held simultaneous requests, first tie after reset
        if_req = 1; if_addr = 3'd2; cf_req = 1; cf_addr = 3'd5;
        grants = 0; lastc = 0; t = 0;
        while (grants < 8 && t < 40) begin
            @(negedge clk);
            t++;
            if (if_gnt | cf_gnt) begin
                who = cf_gnt ? 1 : 0;
`ifdef ROM_ARB_FIXED_PRIO_EN
                expw = 0;
`else
                expw = grants % 2;
`endif
                chk("tie_order", 32'(who), 32'(expw));
                if (grants > 0) chk("tie_gap", 32'(cyc - lastc), 32'd2);
                lastc = cyc;
                if (who == 1) cf_q.push_back(rom[5]);
                else if_q.push_back(rom[2]);
                grants++;
            end
        end
        if_req = 0; cf_req = 0;
        chk("tie_grant_count", 32'(grants), 32'd8);
        repeat (3) @(negedge clk);

        // single IF read of ROM[1]
        if_req = 1; if_addr = 3'd1; if_q.push_back(rom[1]);
        @(negedge clk);
        chk("single_gnt", {31'd0, if_gnt}, 32'd1);
        chk("single_addr", {29'd0, ROM_address}, 32'd1);
        if_req = 0;
        @(negedge clk);
        chk("single_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("single_rdata", {24'd0, rdata}, 32'hA5);
        @(negedge clk);
        chk("single_done", {28'd0, if_gnt, cf_gnt, if_rvalid, cf_rvalid},
            32'd0);
        chk("rdata_hold", {24'd0, rdata}, 32'hA5);

        // CF request raised while busy
        if_req = 1; if_addr = 3'd4; if_q.push_back(rom[4]);
        @(negedge clk);
        chk("rdr_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("rdr_busy", {31'd0, busy}, 32'd1);
        if_req = 0;
        cf_req = 1; cf_addr = 3'd6; cf_q.push_back(rom[6]);
        @(negedge clk);
        chk("rdr_cf_early", {31'd0, cf_gnt}, 32'd0);
        @(negedge clk);
        chk("rdr_cf_gnt", {31'd0, cf_gnt}, 32'd1);
        cf_req = 0;
        repeat (2) @(negedge clk);

        // back-to-back CF
        do_req(1'b1, 3'd3, g1);
        @(negedge clk);
        do_req(1'b1, 3'd7, g2);
        chk("b2b_gap_ok", 32'((g2 - g1) >= 2), 32'd1);
        repeat (3) @(negedge clk);

        // reset in the middle of an IF access
        if_req = 1; if_addr = 3'd6; if_q.push_back(rom[6]);
        @(negedge clk);
        chk("mid_gnt", {31'd0, if_gnt}, 32'd1);
        rst_n = 1'b0; if_req = 0;
        #1;
        chk("mid_rst_addr", {29'd0, ROM_address}, 32'd0);
        chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        chk("mid_rst_gnt", {31'd0, if_gnt}, 32'd0);
        if_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_rvalid", {31'd0, if_rvalid}, 32'd0);
        end
        rst_n = 1'b1;
        if_req = 1; if_addr = 3'd0; cf_req = 1; cf_addr = 3'd7;
        got = 0;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            got = if_gnt | cf_gnt;
        end
        chk("post_rst_tie_if", {30'd0, if_gnt, cf_gnt}, 32'd2);
        if (if_gnt) if_q.push_back(rom[0]);
        if (cf_gnt) cf_q.push_back(rom[7]);
        if_req = 0; cf_req = 0;
        repeat (3) @(negedge clk);

        // randomized traffic from both requesters
        fork
            begin
                int gc;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    do_req(1'b0, 3'($urandom_range(0, 7)), gc);
                end
            end
            begin
                int gc;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    do_req(1'b1, 3'($urandom_range(0, 7)), gc);
                end
            end
        join

        for (int n = 0; n < 10 && (if_q.size() + cf_q.size()) != 0; n++)
            @(negedge clk);
        chk("drain", 32'(if_q.size() + cf_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
